// File: rtl/blk_mem_bridge.sv
// Block-to-word memory bridge: splits an arbiter block request into XLEN beats on a
// req/ack word bus and reassembles read beats into one block with a ready pulse.
module blk_mem_bridge #(
  parameter int unsigned BLK_SIZE = 128,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_req_valid_i,
  input  logic [ADDR_W-1:0]       mem_req_addr_i,
  input  logic [BLK_SIZE/8-1:0]   mem_req_rw_i,
  input  logic [BLK_SIZE-1:0]     mem_req_data_i,
  output logic                    mem_ready_o,
  output logic [BLK_SIZE-1:0]     mem_rdata_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ADDR_W-1:0]       bus_addr_o,
  output logic [XLEN/8-1:0]       bus_wstrb_o,
  output logic [XLEN-1:0]         bus_wdata_o,
  input  logic                    bus_ack_i,
  input  logic [XLEN-1:0]         bus_rdata_i
);

  localparam int unsigned WORDS = BLK_SIZE / XLEN;
  localparam int unsigned SB    = XLEN / 8;
  localparam int unsigned MB    = BLK_SIZE / 8;
  localparam int unsigned BOFF  = $clog2(MB);
  localparam int unsigned WOFF  = $clog2(SB);
  localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << BOFF) - 64'd1);
  localparam logic [CW-1:0]     LAST_CNT = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MB-1:0]       mask_q, mask_d;
  logic [BLK_SIZE-1:0] data_q, data_d;
  logic [BLK_SIZE-1:0] rdata_q, rdata_d;

  logic [SB-1:0]       strb_c;
  logic [ADDR_W-1:0]   beat_addr_c;
  logic                last_c;

  assign mem_rdata_o = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and bus decode; bus outputs only depend on registered state so they
  // stay stable while a beat waits for its ack.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    mem_ready_o = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wstrb_o = '0;
    bus_wdata_o = '0;
    strb_c      = mask_q[cnt_q*SB +: SB];
    beat_addr_c = addr_q | (ADDR_W'(cnt_q) << WOFF);
    last_c      = (cnt_q == LAST_CNT);

    unique case (state_q)
      IDLE: begin
        if (mem_req_valid_i) begin
          addr_d  = mem_req_addr_i & ~OFF_MASK;
          mask_d  = mem_req_rw_i;
          data_d  = mem_req_data_i;
          cnt_d   = '0;
          state_d = (|mem_req_rw_i) ? WRITE : READ;
        end
      end

      READ: begin
        bus_req_o  = 1'b1;
        bus_addr_o = beat_addr_c;
        if (bus_ack_i) begin
          rdata_d[cnt_q*XLEN +: XLEN] = bus_rdata_i;
          if (last_c) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WRITE: begin
        // Words with an empty mask slice cost one idle clock and no bus cycle.
        bus_req_o   = |strb_c;
        bus_we_o    = 1'b1;
        bus_addr_o  = beat_addr_c;
        bus_wstrb_o = strb_c;
        bus_wdata_o = data_q[cnt_q*XLEN +: XLEN];
        if (!(|strb_c) || bus_ack_i) begin
          if (last_c) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RESP: begin
        mem_ready_o = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_blk_mem_bridge.sv
// Self-checking bench for blk_mem_bridge: table vectors, directed corner sequences and
// random requests against a word-memory slave and a block-level expectation model.
module tb_blk_mem_bridge;

  localparam int unsigned BLK   = 128;
  localparam int unsigned XL    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned WORDS = BLK / XL;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            mem_req_valid_i = 1'b0;
  logic [AW-1:0]   mem_req_addr_i = '0;
  logic [BLK/8-1:0] mem_req_rw_i = '0;
  logic [BLK-1:0]  mem_req_data_i = '0;
  logic            mem_ready_o;
  logic [BLK-1:0]  mem_rdata_o;
  logic            bus_req_o;
  logic            bus_we_o;
  logic [AW-1:0]   bus_addr_o;
  logic [XL/8-1:0] bus_wstrb_o;
  logic [XL-1:0]   bus_wdata_o;
  logic            bus_ack_i = 1'b0;
  logic [XL-1:0]   bus_rdata_i = '0;

  blk_mem_bridge #(.BLK_SIZE(BLK), .XLEN(XL), .ADDR_W(AW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .mem_req_valid_i (mem_req_valid_i),
    .mem_req_addr_i  (mem_req_addr_i),
    .mem_req_rw_i    (mem_req_rw_i),
    .mem_req_data_i  (mem_req_data_i),
    .mem_ready_o     (mem_ready_o),
    .mem_rdata_o     (mem_rdata_o),
    .bus_req_o       (bus_req_o),
    .bus_we_o        (bus_we_o),
    .bus_addr_o      (bus_addr_o),
    .bus_wstrb_o     (bus_wstrb_o),
    .bus_wdata_o     (bus_wdata_o),
    .bus_ack_i       (bus_ack_i),
    .bus_rdata_i     (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;

  function automatic logic [68:0] beat_bits(input beat_t b);
    return {b.addr, b.we, b.strb, b.wdata};
  endfunction

  // Word memory behind the bus; unseen words get random contents on first touch.
  logic [31:0] tbmem [logic [31:0]];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (!tbmem.exists(a)) tbmem[a] = $urandom;
    return tbmem[a];
  endfunction

  beat_t       log_q[$];
  int          dly      = 0;
  bit          stray_en = 1'b0;
  int          wcnt     = 0;
  bit          waiting  = 1'b0;
  beat_t       held;
  logic [BLK-1:0] model_rdata = '0;

  // Bus slave: acks each beat after dly wait cycles, checks the beat holds meanwhile.
  always @(negedge clk_i) begin
    beat_t       b;
    logic [31:0] w;
    bus_ack_i = 1'b0;
    b.addr  = bus_addr_o;
    b.we    = bus_we_o;
    b.strb  = bus_wstrb_o;
    b.wdata = bus_wdata_o;
    if (rst_i) begin
      wcnt    = 0;
      waiting = 1'b0;
    end else if (bus_req_o) begin
      if (waiting) chk("beat_hold", 128'(beat_bits(b)), 128'(beat_bits(held)));
      if (wcnt >= dly) begin
        bus_ack_i = 1'b1;
        wcnt      = 0;
        waiting   = 1'b0;
        log_q.push_back(b);
        if (b.we) begin
          w = rd_word(b.addr);
          for (int k = 0; k < 4; k++) if (b.strb[k]) w[k*8 +: 8] = b.wdata[k*8 +: 8];
          tbmem[b.addr] = w;
        end else begin
          bus_rdata_i = rd_word(b.addr);
        end
      end else begin
        wcnt++;
        waiting = 1'b1;
        held    = b;
      end
    end else begin
      wcnt    = 0;
      waiting = 1'b0;
      if (stray_en) bus_ack_i = 1'($urandom_range(0, 1));
      bus_rdata_i = $urandom;
    end
  end

  // One block request: expected beats, block and latency come from the block-level rules.
  task automatic do_req(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d,
                        input int dl, input bit st, input bit scr, input int lat_hand,
                        input bit keep, input bit b2b);
    logic [31:0]  base;
    logic [127:0] exp_rd;
    logic [3:0]   ms;
    beat_t        e;
    beat_t        exp_q[$];
    int           lat;
    int           cyc;
    bit           got;
    base     = a & ~32'hF;
    dly      = dl;
    stray_en = st;
    exp_rd   = model_rdata;
    lat      = 1;
    for (int i = 0; i < WORDS; i++) begin
      ms = m[i*4 +: 4];
      e.addr = base + 32'(i * 4);
      if (m == 16'h0) begin
        e.we = 1'b0; e.strb = 4'h0; e.wdata = '0;
        exp_rd[i*32 +: 32] = rd_word(e.addr);
        exp_q.push_back(e);
        lat += dl + 1;
      end else if (ms != 4'h0) begin
        e.we = 1'b1; e.strb = ms; e.wdata = d[i*32 +: 32];
        exp_q.push_back(e);
        lat += dl + 1;
      end else begin
        lat += 1;
      end
    end
    if (b2b) lat += 1;
    if (lat_hand >= 0) lat = lat_hand;
    log_q.delete();
    mem_req_valid_i = 1'b1;
    mem_req_addr_i  = a;
    mem_req_rw_i    = m;
    mem_req_data_i  = d;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      if (b2b && cyc == 1) chk("b2b_idle_gap", 128'({mem_ready_o, bus_req_o}), 128'(0));
      if (mem_ready_o) got = 1'b1;
      else if (scr && cyc > (b2b ? 1 : 0)) begin
        mem_req_addr_i = $urandom;
        mem_req_rw_i   = 16'($urandom);
        mem_req_data_i = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    chk("ready_seen", 128'(got), 128'(1));
    chk("latency", 128'(cyc), 128'(lat));
    chk("rdata", mem_rdata_o, exp_rd);
    chk("nbeats", 128'(log_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk("beat", 128'(beat_bits(log_q[i])), 128'(beat_bits(exp_q[i])));
    model_rdata = exp_rd;
    if (!keep) begin
      mem_req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("ready_single", 128'({mem_ready_o, bus_req_o}), 128'(0));
      chk("rdata_hold", mem_rdata_o, exp_rd);
    end
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic [15:0]  mask;
    logic [127:0] data;
    int           dl;
    bit           stray;
    bit           scr;
    int           exp_lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int          cyc;
    logic [31:0] ra;
    logic [15:0] rm;

    vt[0] = '{32'h0000_2000, 16'h00F0, 128'h00000000_00000000_DEADBEEF_00000000, 0, 1'b0, 1'b0, 5};
    vt[1] = '{32'h0000_3008, 16'h0000, 128'h0, 3, 1'b0, 1'b0, 17};
    vt[2] = '{32'h0000_4000, 16'hFFFF, 128'h44444444_33333333_22222222_11111111, 0, 1'b0, 1'b0, 5};
    vt[3] = '{32'h0000_400C, 16'h8001, 128'hCAFE0003_0BAD0002_0BAD0001_F00D0000, 2, 1'b1, 1'b0, 9};
    vt[4] = '{32'h0000_5ABC, 16'h0000, 128'h0, 1, 1'b1, 1'b1, 9};
    vt[5] = '{32'h0000_4000, 16'h0F00, 128'h55555555_66666666_77777777_88888888, 0, 1'b1, 1'b1, 5};
    vt[6] = '{32'h0000_2000, 16'h0000, 128'h0, 0, 1'b0, 1'b0, 5};

    tbmem[32'h1230] = 32'hA0;
    tbmem[32'h1234] = 32'hA1;
    tbmem[32'h1238] = 32'hA2;
    tbmem[32'h123C] = 32'hA3;

    @(negedge clk_i);
    chk("reset_outs", 128'({bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o, mem_ready_o}), 128'(0));
    chk("reset_rdata", mem_rdata_o, 128'(0));
    rst_i = 1'b0;
    @(negedge clk_i);

    // Zero-wait read from the named test case.
    do_req(32'h0000_1234, 16'h0, 128'h0, 0, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    chk("read_block", mem_rdata_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    for (int i = 0; i < 7; i++)
      do_req(vt[i].addr, vt[i].mask, vt[i].data, vt[i].dl, vt[i].stray, vt[i].scr,
             vt[i].exp_lat, 1'b0, 1'b0);
    chk("write_landed", 128'(tbmem[32'h2004]), 128'(32'hDEADBEEF));

    // Stray acks while idle must not start anything.
    stray_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      chk("stray_idle", 128'({mem_ready_o, bus_req_o}), 128'(0));
    end
    stray_en = 1'b0;

    // Back-to-back: valid stays high across ready, next request waits one idle cycle.
    do_req(32'h0000_7000, 16'h0, 128'h0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    do_req(32'h0000_7100, 16'h0F0F, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 0, 1'b0, 1'b0, 6, 1'b1, 1'b1);
    do_req(32'h0000_7100, 16'h0, 128'h0, 1, 1'b0, 1'b1, 10, 1'b0, 1'b1);

    // Asynchronous reset during beat 2 of a slow read.
    dly = 3;
    log_q.delete();
    mem_req_valid_i = 1'b1;
    mem_req_addr_i  = 32'h0000_6000;
    mem_req_rw_i    = 16'h0;
    cyc = 0;
    while (!(bus_req_o && bus_addr_o == 32'h0000_6008) && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("beat2_reached", 128'({bus_req_o, bus_addr_o}), 128'({1'b1, 32'h0000_6008}));
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_outs", 128'({bus_req_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o, mem_ready_o}), 128'(0));
    chk("rst_async_rdata", mem_rdata_o, 128'(0));
    mem_req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("no_aborted_ready", 128'({mem_ready_o, bus_req_o}), 128'(0));
    end
    do_req(32'h0000_6000, 16'h0, 128'h0, 0, 1'b0, 1'b0, 5, 1'b0, 1'b0);

    // Random requests against the model.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom & 32'h0000_FFFF;
      rm = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
      do_req(ra, rm, {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blk_mem_bridge.md
Name: blk_mem_bridge

Overview:
- Sits directly downstream of the I/D memory arbiter and consumes its block request: valid, block address, per-byte write mask and block data.
- Serialises each block request into XLEN-wide beats on a single-master word bus with a req/ack handshake.
- Reassembles read beats into one BLK_SIZE-wide block and returns it with a one-cycle ready pulse to the arbiter.

Parameters:
- BLK_SIZE, 128: block width in bits; must be a multiple of XLEN.
- XLEN, 32: word bus data width in bits.
- ADDR_W, 32: address width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- mem_req_valid_i  input  1  block request valid; held by requester until mem_ready_o.
- mem_req_addr_i  input  ADDR_W  block request address; low offset bits ignored.
- mem_req_rw_i  input  BLK_SIZE/8  byte write mask; all-zero means read.
- mem_req_data_i  input  BLK_SIZE  block write data.
- mem_ready_o  output  1  one-cycle completion pulse.
- mem_rdata_o  output  BLK_SIZE  assembled read block.
- bus_req_o  output  1  word beat request.
- bus_we_o  output  1  beat is a write.
- bus_addr_o  output  ADDR_W  word-aligned beat address.
- bus_wstrb_o  output  XLEN/8  beat byte strobes.
- bus_wdata_o  output  XLEN  beat write data.
- bus_ack_i  input  1  beat accepted or completed; read data valid this cycle.
- bus_rdata_i  input  XLEN  beat read data.

Behaviour:
- Derived constants: WORDS = BLK_SIZE/XLEN; BOFF = clog2(BLK_SIZE/8); WOFF = clog2(XLEN/8).
- Reset (asynchronous, any state): FSM goes to IDLE; beat counter = 0.
  - All outputs go to 0, including mem_rdata_o and bus_addr_o.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE, mem_req_valid_i = 1:
  - Capture address with offset bits cleared, plus mask and data.
  - Beat counter = 0.
  - Next state is WRITE if the mask is nonzero, else READ.
  - Inputs are ignored from here until the return to IDLE; mid-transaction changes have no effect.
- READ, one beat per counter value 0..WORDS-1:
  - bus_req_o = 1, bus_we_o = 0, bus_wstrb_o = 0.
  - bus_addr_o = {blk_addr[ADDR_W-1:BOFF], cnt, WOFF zeros}.
  - On bus_ack_i: store bus_rdata_i into mem_rdata_o[cnt*XLEN +: XLEN], then increment cnt.
  - After the ack of the last beat, go to RESP.
- WRITE:
  - Issue beats only where mask[cnt*XLEN/8 +: XLEN/8] is nonzero.
  - bus_wstrb_o = that mask slice; bus_wdata_o = data slice for cnt; bus_we_o = 1.
  - Beats with a zero mask slice are skipped without a bus cycle: cnt advances one per clock with bus_req_o = 0.
  - After the last index is acked or skipped, go to RESP.
  - mem_rdata_o is unchanged by writes.
- RESP: mem_ready_o = 1 for exactly one cycle, then go to IDLE.
- IDLE always lasts at least one cycle after RESP, so a still-asserted valid from the finished request is never re-accepted.
- Bus handshake:
  - bus_req_o and all bus_* outputs stay stable until bus_ack_i.
  - Same-cycle ack is legal, giving zero wait states.
  - bus_ack_i while bus_req_o = 0 is ignored.
- Latency: with zero-wait ack, a read accepted at cycle 0 drives beats at cycles 1..WORDS and mem_ready_o at cycle WORDS+1. A full-mask write has the same timing.
- mem_rdata_o holds its value between requests.
- Beat counter width is clog2(WORDS), at least 1 bit. It must not wrap into an extra beat.

Test Plan:
- Read, zero-wait: read of 0x0000_1234 with ack tied 1 and rdata = 0xA0,0xA1,0xA2,0xA3 per beat -> bus_addr 0x1230/34/38/3C at cycles 1-4; mem_ready_o at cycle 5; mem_rdata_o = {A3,A2,A1,A0} words.
- Write, partial mask: mask = 0x00F0 with data word1 = 0xDEADBEEF -> exactly one bus write at addr base+4, wstrb 0xF, wdata 0xDEADBEEF; mem_ready_o a single pulse; mem_rdata_o unchanged.
- Wait states: ack delayed 3 cycles per beat on a read -> bus outputs held stable while waiting; mem_ready_o at cycle 1+4*4.
- Reset mid-burst: rst_i asserted asynchronously during beat 2 of a read -> all outputs 0 immediately. After release, a new read starts from beat 0 with no ready for the aborted request.
- Back-to-back: valid held high across ready -> one RESP pulse, at least one IDLE cycle, then the second request is accepted. Request changes during a burst are ignored.
- Stray ack: ack pulses in IDLE and during skipped write beats -> no state or counter change.
